// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants and scan phase type.
// Consumed by vga_scan_gen and its scan_axis counters.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_D = 640;
  localparam int unsigned H_FP_D     = 16;
  localparam int unsigned H_SYNC_D   = 96;
  localparam int unsigned H_BP_D     = 48;
  localparam int unsigned V_ACTIVE_D = 480;
  localparam int unsigned V_FP_D     = 10;
  localparam int unsigned V_SYNC_D   = 2;
  localparam int unsigned V_BP_D     = 33;

  localparam int unsigned H_TOTAL =
    H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;
  localparam int unsigned V_TOTAL =
    V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } scan_phase_t;

endpackage

// File: rtl/scan_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Reset parks it at the last (blank) position so the first advance hits 0.
module scan_axis
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACT = 640,
  parameter int unsigned FP  = 16,
  parameter int unsigned SYN = 96,
  parameter int unsigned BP  = 48
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        adv_i,
  output logic [15:0] pos_o,
  output logic        wrap_o,
  output scan_phase_t phase_o
);

  localparam int unsigned TOT = ACT + FP + SYN + BP;
  localparam logic [15:0] LAST    = 16'(TOT - 1);
  localparam logic [15:0] E_FRONT = 16'(ACT);
  localparam logic [15:0] E_SYNC  = 16'(ACT + FP);
  localparam logic [15:0] E_BACK  = 16'(ACT + FP + SYN);

  logic [15:0] pos_q, pos_d;
  scan_phase_t ph_q, ph_d;

  assign wrap_o  = adv_i && (pos_q == LAST);
  assign pos_o   = pos_q;
  assign phase_o = ph_q;

  always_comb begin
    pos_d = pos_q;
    ph_d  = ph_q;
    if (adv_i) begin
      pos_d = wrap_o ? 16'd0 : pos_q + 16'd1;
      unique case (ph_q)
        ACTIVE: if (pos_d == E_FRONT) ph_d = FRONT;
        FRONT:  if (pos_d == E_SYNC)  ph_d = SYNC;
        SYNC:   if (pos_d == E_BACK)  ph_d = BACK;
        BACK:   if (pos_d == 16'd0)   ph_d = ACTIVE;
        default: ph_d = BACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pos_q <= LAST;
      ph_q  <= BACK;
    end else begin
      pos_q <= pos_d;
      ph_q  <= ph_d;
    end
  end

endmodule

// File: rtl/vga_scan_gen.sv
// Raster scan generator: pixel-strobe divider plus horizontal/vertical axes.
// Optional SCAN_FRAME_CNT_EN adds an 8-bit wrapping frame counter port.
module vga_scan_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_D,
  parameter int unsigned H_FP     = H_FP_D,
  parameter int unsigned H_SYNC   = H_SYNC_D,
  parameter int unsigned H_BP     = H_BP_D,
  parameter int unsigned V_ACTIVE = V_ACTIVE_D,
  parameter int unsigned V_FP     = V_FP_D,
  parameter int unsigned V_SYNC   = V_SYNC_D,
  parameter int unsigned V_BP     = V_BP_D,
  parameter int unsigned PIX_DIV  = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  output logic        pix_en,
  output logic [15:0] Xcoordinate,
  output logic [15:0] Ycoordinate,
  output logic        hsync,
  output logic        vsync,
  output logic        active,
  output logic        frame_start
`ifdef SCAN_FRAME_CNT_EN
  ,
  output logic [7:0]  frame_cnt
`endif
);

  localparam int unsigned DW = $clog2(PIX_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          pix_en_q, pix_en_d;
  logic          fs_q, fs_d;
  logic          h_wrap, v_wrap;
  scan_phase_t   h_ph, v_ph;

  always_comb begin
    div_d    = div_q;
    pix_en_d = 1'b0;
    if (enable) begin
      pix_en_d = (div_q == DIV_LAST);
      div_d    = pix_en_d ? '0 : div_q + DW'(1);
    end
  end

  // A strobe already issued is always consumed, so freezing never drops a pixel.
  scan_axis #(
    .ACT(H_ACTIVE), .FP(H_FP), .SYN(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk(clk), .reset_n(reset_n), .adv_i(pix_en_q),
    .pos_o(Xcoordinate), .wrap_o(h_wrap), .phase_o(h_ph)
  );

  scan_axis #(
    .ACT(V_ACTIVE), .FP(V_FP), .SYN(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk(clk), .reset_n(reset_n), .adv_i(h_wrap),
    .pos_o(Ycoordinate), .wrap_o(v_wrap), .phase_o(v_ph)
  );

  assign fs_d = h_wrap & v_wrap;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= '0;
      pix_en_q <= 1'b0;
      fs_q     <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_en_q <= pix_en_d;
      fs_q     <= fs_d;
    end
  end

  assign pix_en      = pix_en_q;
  assign frame_start = fs_q;
  assign hsync       = (h_ph != SYNC);
  assign vsync       = (v_ph != SYNC);
  assign active      = (h_ph == ACTIVE) && (v_ph == ACTIVE);

`ifdef SCAN_FRAME_CNT_EN
  logic [7:0] fc_q, fc_d;

  assign fc_d = fs_q ? fc_q + 8'd1 : fc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) fc_q <= 8'd0;
    else          fc_q <= fc_d;
  end

  assign frame_cnt = fc_q;
`endif

endmodule
